// File: rtl/data_memory_unit.sv
// Y86-64 data memory: byte-addressed, little-endian, 8-byte accesses.
// Fixed-latency req/done handshake; faults reported via data_memerror.
module data_memory_unit #(
    parameter int MEM_BYTES = 1024,
    parameter int LATENCY   = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req,
    input  logic [63:0] location,
    input  logic [63:0] wdata,
    input  logic        write_En,
    input  logic        read_En,
    output logic [63:0] valM,
    output logic        data_memerror,
    output logic        busy,
    output logic        done
);

    localparam int          AW   = $clog2(MEM_BYTES);
    localparam logic [63:0] LAST = 64'(MEM_BYTES - 8);
    localparam logic [3:0]  LAT  = 4'(LATENCY);

    typedef enum logic [1:0] {IDLE, WAIT, COMPLETE} state_t;

    state_t        state_q, state_d;
    logic [3:0]    cnt_q, cnt_d;
    logic [AW-1:0] addr_q, addr_d;
    logic [63:0]   wdata_q, wdata_d;
    logic          we_q, we_d;
    logic          re_q, re_d;
    logic          fault_q, fault_d;
    logic [63:0]   valM_q, valM_d;
    logic          err_q, err_d;
    logic          busy_q, busy_d;
    logic          done_q, done_d;
    logic [63:0]   rdata;

    logic [7:0] mem [MEM_BYTES];

    // State, captured request and registered outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            addr_q  <= '0;
            wdata_q <= '0;
            we_q    <= 1'b0;
            re_q    <= 1'b0;
            fault_q <= 1'b0;
            valM_q  <= '0;
            err_q   <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            we_q    <= we_d;
            re_q    <= re_d;
            fault_q <= fault_d;
            valM_q  <= valM_d;
            err_q   <= err_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    // Next state, wait counter and request capture
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        we_d    = we_q;
        re_d    = re_q;
        fault_d = fault_q;
        unique case (state_q)
            IDLE: begin
                if (req) begin
                    addr_d  = location[AW-1:0];
                    wdata_d = wdata;
                    we_d    = write_En;
                    re_d    = read_En;
                    fault_d = (location > LAST) || (write_En && read_En);
                    cnt_d   = LAT;
                    state_d = (LAT == 4'd0) ? COMPLETE : WAIT;
                end
            end
            WAIT: begin
                cnt_d = cnt_q - 4'd1;
                if (cnt_q <= 4'd1) begin
                    state_d = COMPLETE;
                end
            end
            COMPLETE: begin
                cnt_d   = '0;
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Output next values: busy/done pacing and result commit
    always_comb begin
        valM_d = valM_q;
        err_d  = err_q;
        busy_d = busy_q;
        done_d = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (req) begin
                    busy_d = 1'b1;
                end
            end
            COMPLETE: begin
                done_d = 1'b1;
                busy_d = 1'b0;
                err_d  = fault_q;
                if (fault_q) begin
                    valM_d = '0;
                end else if (re_q) begin
                    valM_d = rdata;
                end
            end
            default: begin
            end
        endcase
    end

    // Little-endian assembly of the 8 bytes at the captured address
    always_comb begin
        rdata = '0;
        for (int i = 0; i < 8; i++) begin
            rdata[8*i +: 8] = mem[addr_q + AW'(i)];
        end
    end

    // Store commits on the edge leaving COMPLETE; array is never reset
    always_ff @(posedge clk) begin
        if (state_q == COMPLETE && we_q && !fault_q) begin
            for (int i = 0; i < 8; i++) begin
                mem[addr_q + AW'(i)] <= wdata_q[8*i +: 8];
            end
        end
    end

    assign valM          = valM_q;
    assign data_memerror = err_q;
    assign busy          = busy_q;
    assign done          = done_q;

endmodule

// File: tb/tb_data_memory_unit.sv
// Scoreboard bench for data_memory_unit: random accesses vs byte-array model.
// Also covers boundaries, reset mid-access and a zero-latency build.
module tb_data_memory_unit;

    localparam int MB  = 1024;
    localparam int LAT = 2;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req = 1'b0;
    logic [63:0] location = '0;
    logic [63:0] wdata = '0;
    logic        write_En = 1'b0;
    logic        read_En = 1'b0;
    logic [63:0] valM;
    logic        data_memerror;
    logic        busy;
    logic        done;

    logic        req0 = 1'b0;
    logic [63:0] loc0 = '0;
    logic [63:0] wd0 = '0;
    logic        we0 = 1'b0;
    logic        re0 = 1'b0;
    logic [63:0] valM0;
    logic        err0;
    logic        busy0;
    logic        done0;

    data_memory_unit #(.MEM_BYTES(MB), .LATENCY(LAT)) dut (
        .clk(clk), .rst_n(rst_n), .req(req), .location(location),
        .wdata(wdata), .write_En(write_En), .read_En(read_En),
        .valM(valM), .data_memerror(data_memerror), .busy(busy), .done(done)
    );

    data_memory_unit #(.MEM_BYTES(MB), .LATENCY(0)) dut0 (
        .clk(clk), .rst_n(rst_n), .req(req0), .location(loc0),
        .wdata(wd0), .write_En(we0), .read_En(re0),
        .valM(valM0), .data_memerror(err0), .busy(busy0), .done(done0)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [63:0] v;
        logic        e;
        int          due;
    } exp_t;

    exp_t        sbq[$];
    logic [7:0]  mm [MB];
    logic [63:0] m_valM = '0;
    int          checks = 0;
    int          failures = 0;
    int          cyc = 0;
    int          last_acc = 0;
    bit          chain = 1'b0;

    initial forever @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] want);
        checks++;
        if (act !== want) begin
            failures++;
            $display("FAIL %s got=%h want=%h", nm, act, want);
        end
    endtask

    // Reference: a memory access in terms of bytes, faults and the last valM
    function automatic void model(input logic we, input logic re,
                                  input logic [63:0] loc, input logic [63:0] wd,
                                  output exp_t x);
        x.due = 0;
        if (loc > 64'(MB - 8) || (we && re)) begin
            m_valM = '0;
            x.e = 1'b1;
        end else begin
            x.e = 1'b0;
            if (we) begin
                for (int i = 0; i < 8; i++) mm[int'(loc[9:0]) + i] = wd[8*i +: 8];
            end else if (re) begin
                for (int i = 0; i < 8; i++) m_valM[8*i +: 8] = mm[int'(loc[9:0]) + i];
            end
        end
        x.v = m_valM;
    endfunction

    // Monitor: every done pulse is matched against the oldest expectation
    initial begin : monitor
        exp_t mx;
        logic pd;
        pd = 1'b0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                pd = 1'b0;
            end else begin
                if (done) begin
                    chk("done_twice", pd, 1'b0);
                    if (sbq.size() == 0) begin
                        checks++;
                        failures++;
                        $display("FAIL unexpected_done valM=%h", valM);
                    end else begin
                        mx = sbq.pop_front();
                        chk("valM", valM, mx.v);
                        chk("memerror", data_memerror, mx.e);
                        chk("done_cycle", cyc, mx.due);
                        chk("busy_at_done", busy, 1'b0);
                    end
                end
                pd = done;
            end
        end
    end

    // Present one request; while the DUT is busy the inputs are scrambled
    task automatic issue(input logic we, input logic re, input logic [63:0] loc,
                         input logic [63:0] wd, input bit hold);
        exp_t x;
        int n;
        n = 0;
        @(negedge clk);
        while (busy) begin
            location = {$urandom, $urandom};
            wdata    = {$urandom, $urandom};
            write_En = 1'($urandom);
            read_En  = 1'($urandom);
            if (!hold) req = 1'($urandom);
            n++;
            if (n > 64) begin
                checks++;
                failures++;
                $display("FAIL busy_timeout got=1 want=0");
                return;
            end
            @(negedge clk);
        end
        req = 1'b1;
        write_En = we;
        read_En = re;
        location = loc;
        wdata = wd;
        @(posedge clk);
        model(we, re, loc, wd, x);
        x.due = cyc + LAT + 2;
        if (chain && hold) chk("accept_spacing", 64'(cyc - last_acc), 64'(LAT + 2));
        last_acc = cyc;
        chain = hold;
        sbq.push_back(x);
        #1;
        if (!hold) req = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge clk);
            req = 1'b0;
        end
        chain = 1'b0;
    endtask

    task automatic drain();
        int k;
        k = 0;
        req = 1'b0;
        while (sbq.size() != 0 && k < 200) begin
            @(negedge clk);
            k++;
        end
        @(negedge clk);
        if (sbq.size() != 0) begin
            checks++;
            failures++;
            $display("FAIL drain_timeout pending=%0d want=0", sbq.size());
            sbq.delete();
        end
        chain = 1'b0;
    endtask

    initial begin : stim
        logic [63:0] loc;
        logic [63:0] d;
        int r;

        repeat (3) @(negedge clk);
        chk("rst_busy", busy, 1'b0);
        chk("rst_done", done, 1'b0);
        chk("rst_valM", valM, 64'h0);
        chk("rst_err", data_memerror, 1'b0);
        chk("rst0_busy", busy0, 1'b0);
        chk("rst0_valM", valM0, 64'h0);
        rst_n = 1'b1;

        for (int a = 0; a < MB; a += 8) issue(1'b1, 1'b0, 64'(a), {$urandom, $urandom}, 1'b1);
        idle(2);

        issue(1'b1, 1'b0, 64'h100, 64'h1122334455667788, 1'b0);
        issue(1'b0, 1'b1, 64'h100, 64'h0, 1'b0);
        issue(1'b0, 1'b1, 64'h0FD, 64'h0, 1'b0);

        issue(1'b0, 1'b1, 64'd1016, 64'h0, 1'b0);
        issue(1'b0, 1'b1, 64'd1017, 64'h0, 1'b0);
        issue(1'b1, 1'b0, 64'hFFFF_FFFF_FFFF_FFF9, 64'hCAFE_F00D_0BAD_BEEF, 1'b0);
        issue(1'b0, 1'b1, 64'h0, 64'h0, 1'b0);

        issue(1'b1, 1'b1, 64'h200, 64'hAAAA_5555_AAAA_5555, 1'b0);
        issue(1'b0, 1'b1, 64'h200, 64'h0, 1'b0);
        issue(1'b0, 1'b0, 64'h300, 64'h1234, 1'b0);
        issue(1'b0, 1'b0, 64'd2000, 64'h0, 1'b0);

        idle(1);
        repeat (6) issue(1'b0, 1'b1, 64'($urandom_range(0, 1016)), 64'h0, 1'b1);
        idle(2);

        repeat (200) begin
            r = $urandom_range(0, 9);
            if (r == 0) loc = {$urandom, $urandom};
            else if (r == 1) loc = 64'(1000 + $urandom_range(0, 40));
            else loc = 64'($urandom_range(0, 1016));
            d = {$urandom, $urandom};
            r = $urandom_range(0, 9);
            if (r == 0) issue(1'b1, 1'b1, loc, d, 1'($urandom));
            else if (r == 1) issue(1'b0, 1'b0, loc, d, 1'($urandom));
            else if (r < 6) issue(1'b1, 1'b0, loc, d, 1'($urandom));
            else issue(1'b0, 1'b1, loc, d, 1'($urandom));
            if ($urandom_range(0, 7) == 0) idle($urandom_range(1, 3));
        end
        drain();

        // Write abandoned by reset one cycle after acceptance
        req = 1'b1;
        write_En = 1'b1;
        read_En = 1'b0;
        location = 64'h40;
        wdata = 64'hDEADBEEF;
        @(posedge clk);
        #1;
        req = 1'b0;
        chk("busy_inflight", busy, 1'b1);
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        chk("midrst_busy", busy, 1'b0);
        chk("midrst_done", done, 1'b0);
        chk("midrst_valM", valM, 64'h0);
        chk("midrst_err", data_memerror, 1'b0);
        m_valM = '0;
        @(negedge clk);
        rst_n = 1'b1;
        issue(1'b0, 1'b1, 64'h40, 64'h0, 1'b0);
        drain();

        // Zero-latency instance: done on the cycle after acceptance
        d = {$urandom, $urandom};
        @(negedge clk);
        req0 = 1'b1; we0 = 1'b1; re0 = 1'b0; loc0 = 64'h80; wd0 = d;
        @(posedge clk);
        #1;
        req0 = 1'b0;
        @(negedge clk);
        chk("lat0_wr_early", done0, 1'b0);
        chk("lat0_wr_busy", busy0, 1'b1);
        @(negedge clk);
        chk("lat0_wr_done", done0, 1'b1);
        chk("lat0_wr_err", err0, 1'b0);
        req0 = 1'b1; we0 = 1'b0; re0 = 1'b1; loc0 = 64'h80; wd0 = '0;
        @(posedge clk);
        #1;
        req0 = 1'b0;
        @(negedge clk);
        chk("lat0_rd_early", done0, 1'b0);
        @(negedge clk);
        chk("lat0_rd_done", done0, 1'b1);
        chk("lat0_rd_valM", valM0, d);
        chk("lat0_rd_err", err0, 1'b0);
        @(negedge clk);
        chk("lat0_done_pulse", done0, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
